odd_number_of_signals: RTL and testbench
========================================

Name: odd_number_of_signals

Overview:
- Four-input odd-parity detector for the arithmetic/logic library.
- `out` is purely combinational: 1 when an odd number of in0..in3 are 1.
- It is valid with clk/rst left unconnected.
- Also provides a combinational popcount, a registered parity copy, and a sticky "odd seen" flag, for use in clocked datapaths.

Parameters:
- CNT_W, default 8: width of the optional odd-event counter (legal range 2..32).

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0  input  1  signal bit 0.
- in1  input  1  signal bit 1.
- in2  input  1  signal bit 2.
- in3  input  1  signal bit 3.
- out  output  1  combinational odd parity: in0^in1^in2^in3.
- ones  output  3  combinational count of asserted inputs, 0..4.
- out_q  output  1  `out` registered one cycle.
- odd_seen  output  1  sticky flag, set once out_q has been 1 at any clock edge since reset.
- odd_cnt  output  CNT_W  count of cycles with out=1 (present only with the optional feature).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- out = XOR of in0..in3, zero latency.
  - out is independent of clk and rst, including during reset.
  - Exact truth: out=1 for 1 or 3 inputs high; out=0 for 0, 2 or 4 inputs high.
- ones = in0+in1+in2+in3, zero-extended to 3 bits, combinational.
  - out always equals ones[0].
- out_q:
  - rst=1 forces out_q=0 immediately (asynchronous).
  - Otherwise out_q <= out each rising clk edge; latency is one cycle.
- odd_seen:
  - rst=1 forces 0 immediately.
  - Otherwise odd_seen <= odd_seen | out_q.
  - First set one cycle after out_q rises, i.e. two edges after out first goes high.
  - Stays set until reset.
- Reset values: out_q=0, odd_seen=0, odd_cnt=0.
  - out and ones keep tracking the inputs during reset.
- Reset deasserted mid-stream: the first edge after release samples the current inputs normally; no extra delay.
- X/Z on any input propagates to out/ones. The registers are not required to filter X.
- No state machine and no handshake.

Optional Feature:
- Macro: ODD_NUMBER_OF_SIGNALS_CNT_EN.
- Defined:
  - odd_cnt exists.
  - rst clears it asynchronously to 0.
  - Each rising edge with out=1 increments it by 1.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Undefined:
  - odd_cnt port and counter logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package odd_signals_pkg:
  - N_IN=4.
  - ONES_W=3.
  - default counter width constant (8).
- One natural sub-module, popcount4: four 1-bit inputs; outputs 3-bit count and parity bit.
  - The top instantiates it once.
  - The top adds the out_q/odd_seen/odd_cnt registers.

Test Plan:
- Exhaustive sweep of in3..in0 from 0000 to 1111, 2 time units per step, clk idle:
  - out sequence = 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0.
  - ones = popcount of the step value.
- rst held high while inputs = 0111:
  - out=1 and ones=3.
  - out_q=0, odd_seen=0.
- Release rst, inputs 0001, clock 3 edges:
  - out_q=1 after edge 1.
  - odd_seen=1 after edge 2 and remains 1 when inputs change to 0011.
- Assert rst asynchronously between edges while out_q=1:
  - out_q and odd_seen drop to 0 without a clock edge.
- With ODD_NUMBER_OF_SIGNALS_CNT_EN, CNT_W=2, inputs 1000 held for 5 edges:
  - odd_cnt = 1, 2, 3, 3, 3 (saturates).
  - Then inputs 1100: odd_cnt holds at 3.

Source files
------------

// File: rtl/odd_signals_pkg.sv
// Shared constants for the four-input odd-parity detector family.
// The counter width default applies when ODD_NUMBER_OF_SIGNALS_CNT_EN is defined.
package odd_signals_pkg;

  localparam int N_IN          = 4;
  localparam int ONES_W        = 3;
  localparam int CNT_W_DEFAULT = 8;

endpackage : odd_signals_pkg

// File: rtl/odd_number_of_signals_popcount4.sv
// popcount4: combinational population count and odd parity of four 1-bit inputs.
module popcount4
  import odd_signals_pkg::*;
(
  input  logic              a0,
  input  logic              a1,
  input  logic              a2,
  input  logic              a3,
  output logic [ONES_W-1:0] ones,
  output logic              parity
);

  // Plain XOR/add so X or Z on any input reaches both outputs unfiltered.
  assign ones   = {2'b00, a0} + {2'b00, a1} + {2'b00, a2} + {2'b00, a3};
  assign parity = a0 ^ a1 ^ a2 ^ a3;

endmodule : popcount4

// File: rtl/odd_number_of_signals.sv
// Four-input odd-parity detector with popcount, registered parity and sticky odd flag.
// Define ODD_NUMBER_OF_SIGNALS_CNT_EN to add the saturating odd_cnt counter (width CNT_W).
module odd_number_of_signals
  import odd_signals_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in0,
  input  logic              in1,
  input  logic              in2,
  input  logic              in3,
  output logic              out,
  output logic [ONES_W-1:0] ones,
  output logic              out_q,
  output logic              odd_seen
`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
  ,
  output logic [CNT_W-1:0]  odd_cnt
`endif
);

  // out and ones never touch clk or rst, so they stay live during reset.
  popcount4 u_popcount4 (
    .a0     (in0),
    .a1     (in1),
    .a2     (in2),
    .a3     (in3),
    .ones   (ones),
    .parity (out)
  );

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what gives odd_seen its extra cycle behind out_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 1'b0;
      odd_seen <= 1'b0;
    end else begin
      out_q    <= out;
      odd_seen <= odd_seen | out_q;
    end
  end

`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd_cnt <= '0;
    end else if (out && (odd_cnt != CNT_MAX)) begin
      odd_cnt <= odd_cnt + CNT_W'(1);
    end
  end
`endif

endmodule : odd_number_of_signals

// File: tb/tb_odd_number_of_signals.sv
// Self-checking bench for odd_number_of_signals: directed sweep/reset cases plus random run
// against a count-based reference model; covers odd_cnt when ODD_NUMBER_OF_SIGNALS_CNT_EN is set.
module tb_odd_number_of_signals;

  localparam int TB_CNT_W = 2;

  logic       clk;
  logic       rst;
  logic [3:0] sig;
  logic       out;
  logic [2:0] ones;
  logic       out_q;
  logic       odd_seen;
`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
  logic [TB_CNT_W-1:0] odd_cnt;
`endif

  int n_vec;
  int n_err;

  // Reference model state
  int m_q;
  int m_seen;
  int m_cnt;

  odd_number_of_signals #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in0      (sig[0]),
    .in1      (sig[1]),
    .in2      (sig[2]),
    .in3      (sig[3]),
    .out      (out),
    .ones     (ones),
    .out_q    (out_q),
    .odd_seen (odd_seen)
`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
    ,
    .odd_cnt  (odd_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_ones(input logic [3:0] v);
    return $countones(v);
  endfunction

  task automatic model_reset();
    m_q    = 0;
    m_seen = 0;
    m_cnt  = 0;
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".out"},  {31'd0, out}, model_ones(sig) % 2);
    check({tag, ".ones"}, {29'd0, ones}, model_ones(sig));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"},    {31'd0, out_q},    m_q);
    check({tag, ".odd_seen"}, {31'd0, odd_seen}, m_seen);
`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
    check({tag, ".odd_cnt"},  {30'd0, odd_cnt},  m_cnt);
`endif
  endtask

  // One full clock cycle; model advances with the pre-edge inputs, outputs sampled mid-high.
  task automatic tick(input string tag);
    int odd_now;
    odd_now = model_ones(sig) % 2;
    if (!rst) begin
      m_seen = (m_seen != 0 || m_q != 0) ? 1 : 0;
      m_q    = odd_now;
      if (odd_now == 1 && m_cnt < (1 << TB_CNT_W) - 1) m_cnt = m_cnt + 1;
    end
    clk = 1'b1;
    #4;
    check_regs(tag);
    #1 clk = 1'b0;
    #5;
  endtask

  initial begin
    logic [15:0] par_tab;
    n_vec   = 0;
    n_err   = 0;
    clk     = 1'b0;
    rst     = 1'b0;
    sig     = 4'b0000;
    par_tab = 16'h6996;
    model_reset();

    // Exhaustive sweep with the clock idle
    for (int i = 0; i < 16; i++) begin
      sig = 4'(i);
      #1;
      check("sweep.out", {31'd0, out}, {31'd0, par_tab[i]});
      check("sweep.ones", {29'd0, ones}, model_ones(sig));
      #1;
    end

    // Combinational outputs live during reset, registers held at zero
    rst = 1'b1;
    sig = 4'b0111;
    #1;
    model_reset();
    check("rst.out", {31'd0, out}, 1);
    check("rst.ones", {29'd0, ones}, 3);
    check_regs("rst");
    #4;

    // Release and watch out_q then odd_seen rise
    rst = 1'b0;
    sig = 4'b0001;
    #5;
    tick("rel.e1");
    check("rel.e1.out_q", {31'd0, out_q}, 1);
    tick("rel.e2");
    check("rel.e2.odd_seen", {31'd0, odd_seen}, 1);
    sig = 4'b0011;
    tick("rel.e3");
    check("rel.e3.odd_seen", {31'd0, odd_seen}, 1);
    check("rel.e3.out_q", {31'd0, out_q}, 0);

    // Asynchronous reset between edges while out_q is high
    sig = 4'b0001;
    tick("async.pre");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async.out_q", {31'd0, out_q}, 0);
    check("async.odd_seen", {31'd0, odd_seen}, 0);
    check_regs("async");
    #2 rst = 1'b0;

`ifdef ODD_NUMBER_OF_SIGNALS_CNT_EN
    // Saturating counter with CNT_W = 2
    sig = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick("cnt.sat");
      check("cnt.seq", {30'd0, odd_cnt}, (k < 3) ? k + 1 : 3);
    end
    sig = 4'b1100;
    tick("cnt.hold");
    check("cnt.hold.val", {30'd0, odd_cnt}, 3);
    #1 rst = 1'b1;
    #1 model_reset();
    check_regs("cnt.clr");
    #1 rst = 1'b0;
    #2;
`endif

    // Randomized run with occasional mid-cycle asynchronous resets
    for (int n = 0; n < 400; n++) begin
      sig = 4'($urandom_range(0, 15));
      #1;
      check_comb("rnd");
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("rnd.rst");
        check_comb("rnd.rst");
        rst = 1'b0;
      end
      #1;
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_odd_number_of_signals
